// File: rtl/user_data_gen_chk.sv
// AXI4-Stream incrementing-word packet generator with optional loopback checker for Aurora link bring-up.
// Define UDG_RX_CHECK_EN to build the RX checker; otherwise the RX outputs are tied to zero.
module user_data_gen_chk #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [15:0]       i_pkt_len,
  input  logic [15:0]       i_gap,
  input  logic [15:0]       i_pkt_num,
  input  logic [KEEP_W-1:0] i_last_keep,
  output logic [DATA_W-1:0] m_axi_tx_tdata,
  output logic [KEEP_W-1:0] m_axi_tx_tkeep,
  output logic              m_axi_tx_tlast,
  output logic              m_axi_tx_tvalid,
  input  logic              m_axi_tx_tready,
  input  logic [DATA_W-1:0] s_axi_rx_tdata,
  input  logic [KEEP_W-1:0] s_axi_rx_tkeep,
  input  logic              s_axi_rx_tlast,
  input  logic              s_axi_rx_tvalid,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_tx_pkt_cnt,
  output logic [CNT_W-1:0]  o_rx_pkt_cnt,
  output logic [CNT_W-1:0]  o_rx_err_cnt,
  output logic              o_rx_err
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_len, r_gap, r_num, r_beat, r_gap_cnt;
  logic [KEEP_W-1:0]  r_keep;
  logic [DATA_W-1:0]  r_seq;
  logic [CNT_W-1:0]   r_tx_pkt_cnt;
  logic               r_stop_pend, r_done;
  logic               w_start, w_last, w_hs, w_stop, w_cnt_hit, w_run_end;
  logic [CNT_W-1:0]   w_tx_cnt_inc;

  assign w_start      = i_start & (r_state == S_IDLE);
  assign w_last       = (r_state == S_SEND) & (r_beat == r_len - 16'd1);
  assign w_hs         = (r_state == S_SEND) & m_axi_tx_tready;
  assign w_stop       = r_stop_pend | i_stop;
  assign w_tx_cnt_inc = r_tx_pkt_cnt + CNT_W'(1);
  assign w_cnt_hit    = (r_num != 16'd0) & (w_tx_cnt_inc == CNT_W'(r_num));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_end   = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_SEND;
      S_SEND: begin
        // The run can only end on a packet boundary, so a pending stop waits for tlast.
        if (w_hs && w_last) begin
          if (w_cnt_hit || w_stop) begin
            w_state_nxt = S_IDLE;
            w_run_end   = 1'b1;
          end else if (r_gap != 16'd0) begin
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
          w_run_end   = 1'b1;
        end else if (r_gap_cnt == 16'd1) begin
          w_state_nxt = S_SEND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len        <= '0;
      r_gap        <= '0;
      r_num        <= '0;
      r_keep       <= '1;
      r_seq        <= '0;
      r_beat       <= '0;
      r_gap_cnt    <= '0;
      r_tx_pkt_cnt <= '0;
      r_stop_pend  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_run_end;
      if (w_start) begin
        r_len        <= (i_pkt_len == 16'd0) ? 16'd1 : i_pkt_len;
        r_gap        <= i_gap;
        r_num        <= i_pkt_num;
        r_keep       <= (i_last_keep == '0) ? '1 : i_last_keep;
        r_seq        <= '0;
        r_beat       <= '0;
        r_tx_pkt_cnt <= '0;
        r_stop_pend  <= 1'b0;
      end else begin
        if (r_state != S_IDLE && i_stop) r_stop_pend <= 1'b1;
        if (w_run_end)                   r_stop_pend <= 1'b0;
        if (w_hs) begin
          r_seq <= r_seq + DATA_W'(1);
          if (w_last) begin
            r_beat       <= '0;
            r_tx_pkt_cnt <= w_tx_cnt_inc;
          end else begin
            r_beat <= r_beat + 16'd1;
          end
        end
        if (w_hs && w_last)         r_gap_cnt <= r_gap;
        else if (r_state == S_GAP)  r_gap_cnt <= r_gap_cnt - 16'd1;
      end
    end
  end

  assign m_axi_tx_tvalid = (r_state == S_SEND);
  assign m_axi_tx_tdata  = r_seq;
  assign m_axi_tx_tlast  = w_last;
  assign m_axi_tx_tkeep  = w_last ? r_keep : '1;
  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;
  assign o_tx_pkt_cnt    = r_tx_pkt_cnt;

`ifdef UDG_RX_CHECK_EN
  logic [DATA_W-1:0] r_rx_exp;
  logic [15:0]       r_rx_idx;
  logic [CNT_W-1:0]  r_rx_pkt_cnt, r_rx_err_cnt;
  logic              r_rx_err;
  logic              w_rx_idx_last, w_rx_bad;

  assign w_rx_idx_last = (r_rx_idx == r_len - 16'd1);
  assign w_rx_bad      = (s_axi_rx_tdata != r_rx_exp) | (s_axi_rx_tlast != w_rx_idx_last) |
                         (s_axi_rx_tlast & (s_axi_rx_tkeep != r_keep));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || w_start) begin
      r_rx_exp     <= '0;
      r_rx_idx     <= '0;
      r_rx_pkt_cnt <= '0;
      r_rx_err_cnt <= '0;
      r_rx_err     <= 1'b0;
    end else if (s_axi_rx_tvalid) begin
      // On a good beat tdata equals the expectation, so this also covers the resync case.
      r_rx_exp <= s_axi_rx_tdata + DATA_W'(1);
      r_rx_idx <= s_axi_rx_tlast ? 16'd0 : r_rx_idx + 16'd1;
      if (s_axi_rx_tlast) r_rx_pkt_cnt <= r_rx_pkt_cnt + CNT_W'(1);
      if (w_rx_bad) begin
        r_rx_err <= 1'b1;
        if (r_rx_err_cnt != '1) r_rx_err_cnt <= r_rx_err_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rx_pkt_cnt = r_rx_pkt_cnt;
  assign o_rx_err_cnt = r_rx_err_cnt;
  assign o_rx_err     = r_rx_err;
`else
  logic w_rx_unused;
  assign w_rx_unused  = ^{s_axi_rx_tdata, s_axi_rx_tkeep, s_axi_rx_tlast, s_axi_rx_tvalid};
  assign o_rx_pkt_cnt = '0;
  assign o_rx_err_cnt = '0;
  assign o_rx_err     = 1'b0;
`endif

endmodule
